// File: rtl/ulpb_tx_msg_sender_if.sv
// Node TX handshake bundle: the message originator drives it through the master
// modport, the node answers through the slave modport.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface ulpb_tx_msg_sender_if;
  logic [`ADDR_WIDTH-1:0] TX_ADDR;
  logic [`DATA_WIDTH-1:0] TX_DATA;
  logic                   TX_PEND;
  logic                   TX_REQ;
  logic                   PRIORITY;
  logic                   TX_ACK;
  logic                   TX_SUCC;
  logic                   TX_FAIL;
  logic                   TX_RESP_ACK;

  modport master (
    output TX_ADDR, TX_DATA, TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK,
    input  TX_ACK, TX_SUCC, TX_FAIL
  );

  modport slave (
    input  TX_ADDR, TX_DATA, TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK,
    output TX_ACK, TX_SUCC, TX_FAIL
  );
endinterface

// File: rtl/ulpb_tx_msg_sender.sv
// Buffers one host message (address + 1..DEPTH words) and plays it out over the node
// TX handshake, reporting the outcome. Define ULPB_TX_RETRY_EN to retransmit on fail.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ulpb_tx_msg_sender #(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                   CLK_EXT,
  input  logic                   RESETn,
  input  logic [`ADDR_WIDTH-1:0] HOST_ADDR,
  input  logic                   HOST_PRIORITY,
  input  logic [`DATA_WIDTH-1:0] HOST_WR_DATA,
  input  logic                   HOST_WR_EN,
  input  logic                   HOST_START,
  output logic                   HOST_BUSY,
  output logic                   HOST_FULL,
  output logic                   HOST_OVF,
  output logic                   HOST_DONE,
  output logic                   HOST_FAIL,
  ulpb_tx_msg_sender_if.master   tx
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_RETRY < 0) begin : g_param_check
    $error("ulpb_tx_msg_sender: DEPTH must be a power of 2 >= 2 and MAX_RETRY >= 0");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ACK_LOW, S_WAIT_RESP, S_RESP_ACK, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       nxt_ptr;
  logic                   busy_q, busy_d;
  logic                   ovf_q, ovf_d;
  logic                   fail_q, fail_d;
  logic                   outcome_q, outcome_d;
  logic                   tx_req_q, tx_req_d;
  logic                   tx_pend_q, tx_pend_d;
  logic                   tx_prio_q, tx_prio_d;
  logic                   resp_ack_q, resp_ack_d;
  logic [`ADDR_WIDTH-1:0] tx_addr_q, tx_addr_d;
  logic [`DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [`DATA_WIDTH-1:0] buf_q [DEPTH];
  logic                   wr_ok;
  logic                   ovf_set;
  logic                   full;
`ifdef ULPB_TX_RETRY_EN
  localparam int RTY_W = $clog2(MAX_RETRY + 1) + 1;
  logic [RTY_W-1:0]       retry_q, retry_d;
`endif

  // TX_PEND for the word at pointer p of a message holding c words
  function automatic logic more_after(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] c);
    return {1'b0, p} != (c - CNT_W'(1));
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign nxt_ptr = rd_ptr_q + PTR_W'(1);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    fail_d     = fail_q;
    outcome_d  = outcome_q;
    tx_req_d   = tx_req_q;
    tx_pend_d  = tx_pend_q;
    tx_prio_d  = tx_prio_q;
    resp_ack_d = resp_ack_q;
    tx_addr_d  = tx_addr_q;
    tx_data_d  = tx_data_q;
`ifdef ULPB_TX_RETRY_EN
    retry_d    = retry_q;
`endif
    wr_ok      = 1'b0;
    ovf_set    = 1'b0;

    // Writes land only while idle; anything else is dropped and flagged.
    if (HOST_WR_EN) begin
      if (state_q == S_IDLE && !full) begin
        wr_ok   = 1'b1;
        count_d = count_q + CNT_W'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (HOST_START) begin
          ovf_d = 1'b0;
          if (count_d != '0) begin
            busy_d    = 1'b1;
            fail_d    = 1'b0;
            rd_ptr_d  = '0;
            tx_addr_d = HOST_ADDR;
            tx_prio_d = HOST_PRIORITY;
            // A word written in the START cycle into an empty buffer is word 0.
            tx_data_d = (count_q == '0) ? HOST_WR_DATA : buf_q[0];
            tx_pend_d = more_after('0, count_d);
            tx_req_d  = 1'b1;
`ifdef ULPB_TX_RETRY_EN
            retry_d   = '0;
`endif
            state_d   = S_REQ;
          end else begin
            fail_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_REQ, S_ACK_LOW: begin
        if (tx.TX_FAIL) begin
          tx_req_d   = 1'b0;
          resp_ack_d = 1'b1;
          outcome_d  = 1'b1;
          state_d    = S_RESP_ACK;
        end else if (state_q == S_REQ) begin
          if (tx.TX_ACK) begin
            tx_req_d = 1'b0;
            state_d  = S_ACK_LOW;
          end
        end else if (!tx.TX_ACK) begin
          if (!more_after(rd_ptr_q, count_q)) begin
            state_d = S_WAIT_RESP;
          end else begin
            rd_ptr_d  = nxt_ptr;
            tx_data_d = buf_q[nxt_ptr];
            tx_pend_d = more_after(nxt_ptr, count_q);
            tx_req_d  = 1'b1;
            state_d   = S_REQ;
          end
        end
      end
      S_WAIT_RESP: begin
        if (tx.TX_SUCC || tx.TX_FAIL) begin
          resp_ack_d = 1'b1;
          outcome_d  = tx.TX_FAIL;
          state_d    = S_RESP_ACK;
        end
      end
      S_RESP_ACK: begin
        if (!tx.TX_SUCC && !tx.TX_FAIL) begin
          resp_ack_d = 1'b0;
`ifdef ULPB_TX_RETRY_EN
          if (outcome_q && retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d   = retry_q + RTY_W'(1);
            outcome_d = 1'b0;
            rd_ptr_d  = '0;
            tx_data_d = buf_q[0];
            tx_pend_d = more_after('0, count_q);
            tx_req_d  = 1'b1;
            state_d   = S_REQ;
          end else
`endif
          begin
            fail_d  = outcome_q;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        count_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK_EXT or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      fail_q     <= 1'b0;
      outcome_q  <= 1'b0;
      tx_req_q   <= 1'b0;
      tx_pend_q  <= 1'b0;
      tx_prio_q  <= 1'b0;
      resp_ack_q <= 1'b0;
      tx_addr_q  <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      fail_q     <= fail_d;
      outcome_q  <= outcome_d;
      tx_req_q   <= tx_req_d;
      tx_pend_q  <= tx_pend_d;
      tx_prio_q  <= tx_prio_d;
      resp_ack_q <= resp_ack_d;
      tx_addr_q  <= tx_addr_d;
      tx_data_q  <= tx_data_d;
    end
  end

`ifdef ULPB_TX_RETRY_EN
  always_ff @(posedge CLK_EXT or negedge RESETn) begin
    if (!RESETn) retry_q <= '0;
    else         retry_q <= retry_d;
  end
`endif

  // Message storage is data only; reset discards it by clearing count.
  always_ff @(posedge CLK_EXT) begin
    if (wr_ok) buf_q[count_q[PTR_W-1:0]] <= HOST_WR_DATA;
  end

  assign HOST_BUSY      = busy_q;
  assign HOST_FULL      = full;
  assign HOST_OVF       = ovf_q;
  assign HOST_DONE      = (state_q == S_DONE);
  assign HOST_FAIL      = fail_q;
  assign tx.TX_ADDR     = tx_addr_q;
  assign tx.TX_DATA     = tx_data_q;
  assign tx.TX_PEND     = tx_pend_q;
  assign tx.TX_REQ      = tx_req_q;
  assign tx.PRIORITY    = tx_prio_q;
  assign tx.TX_RESP_ACK = resp_ack_q;
endmodule

// File: tb/tb_ulpb_tx_msg_sender.sv
// Randomized bench for ulpb_tx_msg_sender: a behavioural node answers the TX handshake
// and the presented word stream and outcome are compared with a per-attempt model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_ulpb_tx_msg_sender;
  localparam int DEPTH     = 4;
  localparam int MAX_RETRY = 3;
  localparam int AW        = `ADDR_WIDTH;
  localparam int DW        = `DATA_WIDTH;
  localparam int TMO       = 64;
`ifdef ULPB_TX_RETRY_EN
  localparam int ATTEMPTS  = MAX_RETRY + 1;
`else
  localparam int ATTEMPTS  = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] host_addr;
  logic          host_prio;
  logic [DW-1:0] host_wr_data;
  logic          host_wr_en;
  logic          host_start;
  logic          host_busy, host_full, host_ovf, host_done, host_fail;

  ulpb_tx_msg_sender_if bus();

  ulpb_tx_msg_sender #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
    .CLK_EXT      (clk),
    .RESETn       (rst_n),
    .HOST_ADDR    (host_addr),
    .HOST_PRIORITY(host_prio),
    .HOST_WR_DATA (host_wr_data),
    .HOST_WR_EN   (host_wr_en),
    .HOST_START   (host_start),
    .HOST_BUSY    (host_busy),
    .HOST_FULL    (host_full),
    .HOST_OVF     (host_ovf),
    .HOST_DONE    (host_done),
    .HOST_FAIL    (host_fail),
    .tx           (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Current message and node behaviour plan (per attempt)
  logic [DW-1:0] msg_w [DEPTH];
  logic [AW-1:0] msg_addr;
  logic          msg_prio;
  int            msg_n;
  int            fw   [8];   // word index at which the node aborts with TX_FAIL, -1 = none
  bit            rf   [8];   // final response is a fail
  bit            both [8];   // drive TX_SUCC together with a fail response
  logic [DW:0]   got_q [$];
  logic [DW:0]   exp_q [$];
  bit            exp_fail;

  // Expected presented words {pend, data} over all attempts, and the final outcome.
  function automatic void model();
    exp_q.delete();
    exp_fail = 1'b1;
    for (int a = 0; a < ATTEMPTS; a++) begin
      int last;
      last = (fw[a] >= 0) ? fw[a] : msg_n - 1;
      for (int i = 0; i <= last; i++) exp_q.push_back({(i != msg_n - 1), msg_w[i]});
      if (fw[a] < 0 && !rf[a]) begin
        exp_fail = 1'b0;
        break;
      end
    end
  endfunction

  function automatic logic probe(input int which);
    case (which)
      0:       return bus.TX_REQ;
      1:       return bus.TX_RESP_ACK;
      default: return host_done;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input string tag, output bit ok);
    int k;
    k = 0;
    while (probe(which) !== val && k < TMO) begin
      @(negedge clk);
      k++;
    end
    ok = (probe(which) === val);
    chk(tag, probe(which), val);
  endtask

  task automatic finish_resp(output bit ok);
    chk("resp_ack_rise", bus.TX_RESP_ACK, 1'b1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    chk("resp_ack_hold", {bus.TX_RESP_ACK, bus.TX_REQ}, 2'b10);
    bus.TX_SUCC = 1'b0;
    bus.TX_FAIL = 1'b0;
    @(negedge clk);
    chk("resp_ack_fall", bus.TX_RESP_ACK, 1'b0);
    ok = 1'b1;
  endtask

  task automatic serve_attempt(input int a, output bit ok);
    bit            w_ok;
    logic [DW-1:0] d;
    logic          p;
    ok = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      wait_for(0, 1'b1, "req_seen", w_ok);
      if (!w_ok) return;
      d = bus.TX_DATA;
      p = bus.TX_PEND;
      got_q.push_back({p, d});
      chk("tx_addr", bus.TX_ADDR, msg_addr);
      chk("tx_prio", bus.PRIORITY, msg_prio);
      chk("no_resp_ack_with_req", bus.TX_RESP_ACK, 1'b0);
      if (fw[a] == i) begin
        bus.TX_FAIL = 1'b1;
        @(negedge clk);
        chk("early_fail_req_drop", bus.TX_REQ, 1'b0);
        finish_resp(ok);
        return;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("req_stable", {bus.TX_REQ, bus.TX_PEND, bus.TX_DATA}, {1'b1, p, d});
      bus.TX_ACK = 1'b1;
      @(negedge clk);
      chk("req_drop_on_ack", bus.TX_REQ, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("req_low_while_ack", bus.TX_REQ, 1'b0);
      bus.TX_ACK = 1'b0;
      @(negedge clk);
      if (!p) break;
      chk("next_req_latency", bus.TX_REQ, 1'b1);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    chk("idle_in_wait_resp", {bus.TX_REQ, bus.TX_RESP_ACK}, 2'b00);
    if (rf[a]) begin
      bus.TX_FAIL = 1'b1;
      bus.TX_SUCC = both[a];
    end else begin
      bus.TX_SUCC = 1'b1;
    end
    @(negedge clk);
    finish_resp(ok);
  endtask

  task automatic serve_msg();
    bit ok;
    for (int a = 0; a < 8; a++) begin
      serve_attempt(a, ok);
      if (!ok) return;
      if (host_done) return;
      chk("retry_or_done", (bus.TX_REQ || host_done), 1'b1);
      if (!bus.TX_REQ) return;
    end
  endtask

  task automatic run_msg(input bit simul, input bit ovf_full, input bit busy_wr);
    bit ok;
    got_q.delete();
    for (int i = 0; i < msg_n; i++) begin
      host_wr_en   = 1'b1;
      host_wr_data = msg_w[i];
      if (simul && i == msg_n - 1) begin
        host_start = 1'b1;
        host_addr  = msg_addr;
        host_prio  = msg_prio;
      end
      @(negedge clk);
    end
    host_wr_en = 1'b0;
    host_start = 1'b0;
    if (ovf_full) begin
      chk("full_at_depth", host_full, 1'b1);
      host_wr_en   = 1'b1;
      host_wr_data = $urandom;
      @(negedge clk);
      host_wr_en = 1'b0;
      chk("ovf_on_full", host_ovf, 1'b1);
      chk("full_hold", host_full, 1'b1);
    end
    if (!simul) begin
      host_start = 1'b1;
      host_addr  = msg_addr;
      host_prio  = msg_prio;
      @(negedge clk);
      host_start = 1'b0;
    end
    chk("start_latency", bus.TX_REQ, 1'b1);
    chk("busy_after_start", host_busy, 1'b1);
    chk("ovf_cleared", host_ovf, 1'b0);
    chk("fail_cleared", host_fail, 1'b0);
    if (busy_wr) begin
      host_wr_en   = 1'b1;
      host_wr_data = $urandom;
      host_start   = 1'b1;
      @(negedge clk);
      host_wr_en = 1'b0;
      host_start = 1'b0;
      chk("ovf_on_busy", host_ovf, 1'b1);
    end
    serve_msg();
    model();
    wait_for(2, 1'b1, "done_seen", ok);
    chk("done_fail", host_fail, exp_fail);
    chk("done_no_req", bus.TX_REQ, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", host_done, 1'b0);
    chk("busy_clear", host_busy, 1'b0);
    chk("buffer_cleared", host_full, 1'b0);
    chk("fail_held", host_fail, exp_fail);
    chk("word_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("word%0d", i), got_q[i], exp_q[i]);
  endtask

  task automatic set_plan(input int f, input bit r);
    for (int a = 0; a < 8; a++) begin
      fw[a]   = f;
      rf[a]   = r;
      both[a] = 1'b0;
    end
  endtask

  task automatic rand_msg();
    for (int i = 0; i < DEPTH; i++) msg_w[i] = $urandom;
    msg_addr = AW'($urandom);
    msg_prio = 1'($urandom);
    for (int a = 0; a < 8; a++) begin
      fw[a]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, msg_n - 1)) : -1;
      rf[a]   = 1'($urandom_range(0, 1));
      both[a] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    host_addr    = '0;
    host_prio    = 1'b0;
    host_wr_data = '0;
    host_wr_en   = 1'b0;
    host_start   = 1'b0;
    bus.TX_ACK   = 1'b0;
    bus.TX_SUCC  = 1'b0;
    bus.TX_FAIL  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_host_outs", {host_busy, host_full, host_ovf, host_done, host_fail}, 5'b0);
    chk("reset_tx_ctrl", {bus.TX_REQ, bus.TX_PEND, bus.PRIORITY, bus.TX_RESP_ACK}, 4'b0);
    chk("reset_tx_addr", bus.TX_ADDR, '0);
    chk("reset_tx_data", bus.TX_DATA, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // single word, success
    msg_n = 1; msg_w[0] = 32'hDEADBEEF; msg_addr = 8'h5A; msg_prio = 1'b0;
    set_plan(-1, 1'b0);
    run_msg(1'b0, 1'b0, 1'b0);

    // full buffer with overflow, four-word burst
    msg_n = 4;
    for (int i = 0; i < 4; i++) msg_w[i] = DW'(i + 1);
    msg_addr = 8'h21; msg_prio = 1'b1;
    run_msg(1'b0, 1'b1, 1'b0);

    // START on an empty buffer
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
    chk("empty_no_req", bus.TX_REQ, 1'b0);
    chk("empty_done", host_done, 1'b1);
    chk("empty_fail", host_fail, 1'b1);
    chk("empty_not_busy", host_busy, 1'b0);
    @(negedge clk);
    chk("empty_done_pulse", host_done, 1'b0);
    chk("empty_fail_held", host_fail, 1'b1);

    // abort during word 2 of 3, on every attempt
    msg_n = 3;
    for (int i = 0; i < 3; i++) msg_w[i] = $urandom;
    msg_addr = 8'h33; msg_prio = 1'b0;
    set_plan(1, 1'b0);
    run_msg(1'b0, 1'b0, 1'b0);

    // node always fails at the response
    msg_n = 2; msg_w[0] = 32'hA5A5_0001; msg_w[1] = 32'hA5A5_0002;
    set_plan(-1, 1'b1);
    run_msg(1'b0, 1'b0, 1'b0);

    // fail, then success on the second attempt
    set_plan(-1, 1'b0);
    rf[0] = 1'b1;
    run_msg(1'b0, 1'b0, 1'b0);

    // asynchronous reset while a request is pending
    for (int i = 0; i < 3; i++) begin
      host_wr_en   = 1'b1;
      host_wr_data = $urandom;
      @(negedge clk);
    end
    host_wr_en = 1'b0;
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
    chk("pre_reset_req", {bus.TX_REQ, host_busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_drops_req", bus.TX_REQ, 1'b0);
    chk("reset_drops_busy", host_busy, 1'b0);
    chk("reset_drops_resp_ack", bus.TX_RESP_ACK, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    msg_n = DEPTH;
    rand_msg();
    set_plan(-1, 1'b0);
    run_msg(1'b0, 1'b1, 1'b0);

    // randomized messages and node behaviour
    for (int t = 0; t < 30; t++) begin
      bit simul, ovf_full, busy_wr;
      msg_n    = $urandom_range(1, DEPTH);
      rand_msg();
      simul    = 1'($urandom_range(0, 1));
      ovf_full = (msg_n == DEPTH) && !simul && ($urandom_range(0, 1) == 1);
      busy_wr  = ($urandom_range(0, 2) == 0);
      run_msg(simul, ovf_full, busy_wr);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
